sys_tx_fifo: RTL

// - Sys-bus peripheral in the processor assembly; sits directly downstream of the core's sys write/read port.
// - Buffers core writes to a DATA register in a FIFO and drains them through a valid/ready stream.
// - Stream consumers are debug, UART and similar.
// - Exposes a STATUS register (count, full, empty, sticky overflow) and a CTRL register (flush, clear overflow).

---
 rtl/sys_tx_fifo.sv | 81 ++++++++
 1 files changed

// File: rtl/sys_tx_fifo.sv
// sys_tx_fifo: sys-bus DATA/STATUS/CTRL registers feeding a first-word-fall-through FIFO drained by a valid/ready stream
module sys_tx_fifo #(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF0000,
    parameter int          DEPTH_LOG2 = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sysw,
    input  logic [31:0] syswa,
    input  logic [31:0] syswl,
    input  logic        sys_read,
    input  logic [31:0] sys_r_addr,
    output logic [31:0] sys_r_line,
    output logic        sys_hit,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = 1;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);

    logic [31:0]           mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic [31:0]           sys_r_line_q, sys_r_line_d;
    logic                  sys_hit_q, sys_hit_d;
    logic                  wr_data, wr_ctrl, full, empty, pop, push, flush, hit_addr;
    logic [31:0]           status;

    assign wr_data   = sysw && syswa == BASE_ADDR;
    assign wr_ctrl   = sysw && syswa == BASE_ADDR + 32'd8;
    assign full      = count_q == CNT_FULL;
    assign empty     = count_q == '0;
    assign pop       = !empty && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
    assign push      = wr_data && (!full || pop);
    assign flush     = wr_ctrl && syswl[0];
    assign status    = {16'b0, 8'(count_q), 5'b0, ovf_q, full, empty};
    assign hit_addr  = sys_r_addr == BASE_ADDR || sys_r_addr == BASE_ADDR + 32'd4 ||
                       sys_r_addr == BASE_ADDR + 32'd8;
    assign out_valid = !empty;
    assign out_data  = mem_q[rd_ptr_q];
    assign sys_r_line = sys_r_line_q;
    assign sys_hit    = sys_hit_q;

    always_comb begin
        wr_ptr_d = flush ? '0 : push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = flush ? '0 : pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = flush ? '0 : (push && !pop) ? count_q + CNT_ONE :
                   (pop && !push) ? count_q - CNT_ONE : count_q;
        ovf_d    = (wr_ctrl && syswl[1]) ? 1'b0 : (wr_data && full && !pop) ? 1'b1 : ovf_q;
        sys_hit_d    = sys_read && hit_addr;
        sys_r_line_d = (sys_read && sys_r_addr == BASE_ADDR + 32'd4) ? status : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ovf_q        <= 1'b0;
            sys_r_line_q <= 32'h0;
            sys_hit_q    <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
            sys_r_line_q <= sys_r_line_d;
            sys_hit_q    <= sys_hit_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push)
            mem_q[wr_ptr_q] <= syswl;
    end
endmodule
